// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and constants for receiver and transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  localparam int BIT_CNT_W = 3;
  localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: bit-period counter flagging the mid-start and full-bit sample points
module uart_rx_sampler #(
  parameter int NO_OF_CLKS = 16,
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic mid,
  output logic full
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) cnt <= (!rst || clr) ? '0 : cnt + 1'b1;
  assign mid  = cnt == W'(NO_OF_CLKS / 2 - 1);
  assign full = cnt == W'(NO_OF_CLKS - 1);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with optional parity; define UART_RX_MAJORITY_VOTE_EN for 2-of-3 bit voting
module uart_rx
  import uart_pkg::*;
#(
  parameter int PARITY_ON = 1,
  parameter int EVEN_PARITY = 1,
  parameter int DATA_SIZE = 8,
  parameter int NO_OF_CLKS = 16,
  parameter int SAMPLING_CNTR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx_s,
  output logic [DATA_SIZE-1:0] Rx_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 busy
);
  localparam logic ODD_PAR = EVEN_PARITY == 0;
  rx_state_t state;
  logic [1:0] sync;
  logic rx_q, bit_val, mid, full, clr, par_bad;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_SIZE-1:0] shift;
  assign rx_q = sync[1];
  assign clr = (state == IDLE) | (state == START ? mid : full);
`ifdef UART_RX_MAJORITY_VOTE_EN
  // sync[0] is the value rx_q takes next cycle, so the vote needs no extra latency
  logic rx_prev;
  always_ff @(posedge clk) rx_prev <= !rst ? 1'b1 : rx_q;
  assign bit_val = (rx_prev & rx_q) | (rx_prev & sync[0]) | (rx_q & sync[0]);
`else
  assign bit_val = rx_q;
`endif
  uart_rx_sampler #(.NO_OF_CLKS(NO_OF_CLKS), .W(SAMPLING_CNTR_WIDTH)) sampler (
    .clk(clk), .rst(rst), .clr(clr), .mid(mid), .full(full)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= 2'b11;
      state <= IDLE;
      bit_cnt <= '0;
      shift <= '0;
      par_bad <= 1'b0;
      Rx_out <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      framing_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      sync <= {sync[0], Rx_s};
      data_valid <= 1'b0;
      case (state)
        IDLE: if (!rx_q) begin
          state <= START;
          busy <= 1'b1;
        end
        START: if (mid) begin
          state <= bit_val ? IDLE : DATA;
          busy <= !bit_val;
          bit_cnt <= '0;
        end
        DATA: if (full) begin
          shift <= {bit_val, shift[DATA_SIZE-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_CNT_W'(DATA_SIZE - 1)) state <= (PARITY_ON != 0) ? PARITY : STOP;
        end
        PARITY: if (full) begin
          par_bad <= ^shift ^ bit_val ^ ODD_PAR;
          state <= STOP;
        end
        STOP: if (full) begin
          Rx_out <= shift;
          data_valid <= 1'b1;
          framing_err <= !bit_val;
          parity_err <= (PARITY_ON != 0) ? par_bad : 1'b0;
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter PARITY_ON, default 1: 1 means a parity bit follows the data bits, 0 means no parity bit.
REQ-002 SHALL have parameter EVEN_PARITY, default 1: 1 means even parity, 0 means odd parity; ignored when PARITY_ON=0.
REQ-003 SHALL have parameter DATA_SIZE, default 8: number of data bits per frame, 5..8.
REQ-004 SHALL have parameter NO_OF_CLKS, default 16: clk cycles per bit period, even, >=4.
REQ-005 SHALL have parameter SAMPLING_CNTR_WIDTH, default 4: sampling counter width, with 2**SAMPLING_CNTR_WIDTH >= NO_OF_CLKS.
REQ-006 SHALL have port clk, input, 1 bit: system clock; the only clock; all logic updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port Rx_s, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port Rx_out, output, DATA_SIZE bits: last received data word.
REQ-010 SHALL have port data_valid, output, 1 bit: one-cycle pulse, high when Rx_out is updated.
REQ-011 SHALL have port parity_err, output, 1 bit: parity result of the frame flagged by data_valid.
REQ-012 SHALL have port framing_err, output, 1 bit: stop-bit result of the frame flagged by data_valid.
REQ-013 SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-014 SHALL pass Rx_s through a 2-flop synchronizer, reset value 1; all line decisions use the synchronized value rx_q.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE SHALL go to START and clear the sampling counter when rx_q=0.
REQ-017 START SHALL sample rx_q when the sampling counter reaches NO_OF_CLKS/2-1. If rx_q=1 it SHALL go to IDLE (false start, no flags); if rx_q=0 it SHALL clear the counter and go to DATA.
REQ-018 DATA SHALL sample rx_q each time the counter reaches NO_OF_CLKS-1, then clear the counter; bits SHALL shift in LSB first; after DATA_SIZE samples it SHALL go to PARITY if PARITY_ON=1, else to STOP.
REQ-019 PARITY SHALL sample one bit after NO_OF_CLKS cycles. The error condition is (XOR of data bits XOR parity bit) != (EVEN_PARITY ? 0 : 1). It SHALL then go to STOP.
REQ-020 STOP SHALL sample after NO_OF_CLKS cycles, then in the same edge: load Rx_out, pulse data_valid for one cycle, set framing_err = ~sample, set parity_err (0 when PARITY_ON=0), and go to IDLE.
REQ-021 SHALL keep parity_err and framing_err constant until the next data_valid.
REQ-022 SHALL keep Rx_out constant between data_valid pulses; a partially received frame SHALL NOT change Rx_out.
REQ-023 A frame with framing_err=1 SHALL still load Rx_out and pulse data_valid.
REQ-024 Because STOP returns to IDLE at mid-stop-bit, a start edge arriving right after the stop bit SHALL be accepted with no lost frame.
REQ-025 Latency: data_valid SHALL rise 2 + NO_OF_CLKS/2 + NO_OF_CLKS*(DATA_SIZE+PARITY_ON+1) cycles after the first clk edge that samples Rx_s=0.

Reset
REQ-026 With rst=0 at a clk edge, state SHALL become IDLE, the counters 0, the synchronizer flops 1, Rx_out 0, and data_valid, parity_err, framing_err and busy 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no data_valid pulse; reception SHALL resume at the next falling edge after rst=1.

Configuration
REQ-028 Macro UART_RX_MAJORITY_VOTE_EN, when defined, SHALL take every bit value (start, data, parity, stop) as the 2-of-3 majority of rx_q at counter values target-1, target and target+1. Defined, latency is unchanged and a single-cycle glitch at the sample point SHALL be rejected.
REQ-029 Without UART_RX_MAJORITY_VOTE_EN, each bit SHALL use a single sample at the target count.

Structure
REQ-030 The FSM state encoding and the bit-count width constant SHALL live in shared package uart_pkg, together with the transmitter's constants.
REQ-031 Sampling counter plus sample-point compare SHALL be sub-module uart_rx_sampler; the FSM and shift register SHALL stay in uart_rx.

Verification
REQ-032 Defaults, frame 0xA5 with parity bit 0 and stop 1 -> Rx_out=0xA5, data_valid pulse at cycle 170, parity_err=0, framing_err=0.
REQ-033 Same frame with parity bit 1 -> Rx_out=0xA5, parity_err=1, framing_err=0.
REQ-034 Frame 0x3C with stop bit 0 -> Rx_out=0x3C, framing_err=1, data_valid pulses once.
REQ-035 Rx_s low for 4 cycles, then high -> no data_valid, busy returns to 0 within NO_OF_CLKS/2+2 cycles.
REQ-036 Back-to-back frames 0x01 and 0xFF, start edge immediately after stop -> two data_valid pulses, Rx_out=0x01 then 0xFF.
REQ-037 rst=0 for one cycle during the DATA state of a 0x55 frame -> no data_valid pulse, Rx_out stays 0, and the next 0x12 frame is received correctly.
